maxnet_param: RTL

- Parametrised winner-take-all (MaxNet) engine: N unsigned W-bit channels, iterative mutual inhibition, one update per clock, until one nonzero activation remains.
- Successor to the fixed 4-channel max finder: adds width/channel/epsilon parameters, an input handshake, winner index output, tie/stall detection, an iteration timeout, and an all-zero input flag.
- Sits between a vector producer (valid/ready) and a consumer that reads the held result while done=1.

---
 rtl/maxnet_param.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/maxnet_param.sv
// -----------------------------------------------------------------------------
// maxnet_param
//   Parametrised winner-take-all (MaxNet) engine. An N x W-bit unsigned vector
//   is accepted over a valid/ready handshake. The working activations Y are
//   then updated once per clock by mutual inhibition:
//     Y_i <= max(0, Y_i - ((sum(Y) - Y_i) >> EPS_SHIFT))
//   This repeats until a single nonzero activation remains. The result (the
//   original value and the index of the winning channel) is held while done=1.
//
//   Optional feature macro: MAXNET_ITER_COUNT_EN
//     defined   -> output iter_count reports the number of Y updates performed
//     undefined -> no iter_count port; the counter is still used for timeout
//
// Parameters
//   N          channel count (>= 2)
//   W          channel width, unsigned
//   EPS_SHIFT  inhibition epsilon = 2^-EPS_SHIFT; N-1 must be < 2^EPS_SHIFT
//   MAX_ITER   update limit before forced termination (>= 1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     input vector valid
//   in_ready     engine can accept a vector (IDLE or DONE)
//   x_flat       input vector, channel i = x_flat[i*W +: W]
//   done         result valid, held until the next accept
//   max_value    original x of the winning channel
//   max_index    winning channel index
//   tie          result resolved by the tie/stall rule
//   timeout      result forced by MAX_ITER
//   no_winner    input vector was all zero
//   iter_count   (MAXNET_ITER_COUNT_EN only) Y updates performed
//   o_dbg_state  FSM state: 0 IDLE, 1 ITER, 2 DONE
//
// Handshake: a vector is transferred on a rising edge where in_valid and
//   in_ready are both 1. in_ready is low for the whole ITER phase, so in_valid
//   and x_flat are ignored there; the producer must hold its vector until it
//   sees in_ready.
// -----------------------------------------------------------------------------
module maxnet_param #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int EPS_SHIFT = 2,
    parameter int MAX_ITER  = 64,
    localparam int IW       = (N > 1) ? $clog2(N) : 1,
    localparam int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    x_flat,
    output logic              done,
    output logic [W-1:0]      max_value,
    output logic [IW-1:0]     max_index,
    output logic              tie,
    output logic              timeout,
    output logic              no_winner,
`ifdef MAXNET_ITER_COUNT_EN
    output logic [CW-1:0]     iter_count,
`endif
    output logic [1:0]        o_dbg_state
);

    // The sum of N W-bit values needs clog2(N) extra bits to never overflow.
    localparam int SW  = W + $clog2(N);
    localparam int NZW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [W-1:0]      r_x [N];
    logic [W-1:0]      r_y [N];
    logic [CW-1:0]     r_iter;
    logic [W-1:0]      r_max_value;
    logic [IW-1:0]     r_max_index;
    logic              r_tie;
    logic              r_timeout;
    logic              r_no_winner;

    logic              w_accept;
    logic [SW-1:0]     w_sum;
    logic [NZW-1:0]    w_nz;
    logic [SW-1:0]     w_inh    [N];
    logic [W-1:0]      w_y_next [N];
    logic              w_next_all_zero;
    logic              w_stall;
    logic [IW-1:0]     w_only_idx;
    logic [IW-1:0]     w_first_idx;
    logic [IW-1:0]     w_argmax_idx;
    logic [W-1:0]      w_argmax_val;
    logic [CW-1:0]     w_iter_inc;
    logic              w_hit_limit;
    logic              w_finish;

    assign w_accept    = in_valid & in_ready;
    assign w_iter_inc  = r_iter + 1'b1;
    assign w_hit_limit = (w_iter_inc == CW'(MAX_ITER));

    // ------------------------------------------------------------------
    // Inhibition datapath, purely combinational on Y
    // ------------------------------------------------------------------
    always_comb begin
        w_sum           = '0;
        w_nz            = '0;
        w_next_all_zero = 1'b1;
        w_stall         = 1'b1;
        w_only_idx      = '0;
        w_first_idx     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + SW'(r_y[i]);
            if (r_y[i] != '0) begin
                w_nz       = w_nz + NZW'(1);
                // Only meaningful when exactly one channel is nonzero.
                w_only_idx = IW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (r_y[i] != '0) begin
                w_first_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            w_inh[i] = (w_sum - SW'(r_y[i])) >> EPS_SHIFT;
            // Clamp at zero: the inhibition can exceed the channel's own value.
            if (w_inh[i] > SW'(r_y[i])) begin
                w_y_next[i] = '0;
            end else begin
                w_y_next[i] = r_y[i] - w_inh[i][W-1:0];
            end
            if (w_y_next[i] != '0) begin
                w_next_all_zero = 1'b0;
            end
            if (w_y_next[i] != r_y[i]) begin
                w_stall = 1'b0;
            end
        end
        // Strict '>' keeps the lowest index on equal values.
        w_argmax_idx = '0;
        w_argmax_val = w_y_next[0];
        for (int i = 1; i < N; i++) begin
            if (w_y_next[i] > w_argmax_val) begin
                w_argmax_val = w_y_next[i];
                w_argmax_idx = IW'(i);
            end
        end
    end

    // The run ends this cycle under any of the four termination rules.
    assign w_finish = (r_state == S_ITER) &&
                      ((w_nz <= NZW'(1)) || w_next_all_zero || w_stall || w_hit_limit);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_ITER;
            S_ITER:  if (w_finish) w_state_next = S_DONE;
            S_DONE:  if (in_valid) w_state_next = S_ITER;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  begin
                in_ready = 1'b1;
                done     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and result
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_iter      <= '0;
            r_max_value <= '0;
            r_max_index <= '0;
            r_tie       <= 1'b0;
            r_timeout   <= 1'b0;
            r_no_winner <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_x[i] <= x_flat[i*W +: W];
                r_y[i] <= x_flat[i*W +: W];
            end
            r_iter      <= '0;
            r_tie       <= 1'b0;
            r_timeout   <= 1'b0;
            r_no_winner <= 1'b0;
        end else if (r_state == S_ITER) begin
            if (w_nz == '0) begin
                r_no_winner <= 1'b1;
                r_max_index <= '0;
                r_max_value <= '0;
            end else if (w_nz == NZW'(1)) begin
                r_max_index <= w_only_idx;
                r_max_value <= r_x[w_only_idx];
            end else if (w_next_all_zero || w_stall) begin
                // Exact ties (or truncation making no progress) never resolve.
                r_tie       <= 1'b1;
                r_max_index <= w_first_idx;
                r_max_value <= r_x[w_first_idx];
            end else begin
                for (int i = 0; i < N; i++) begin
                    r_y[i] <= w_y_next[i];
                end
                r_iter <= w_iter_inc;
                if (w_hit_limit) begin
                    r_timeout   <= 1'b1;
                    r_max_index <= w_argmax_idx;
                    r_max_value <= r_x[w_argmax_idx];
                end
            end
        end
    end

    assign max_value   = r_max_value;
    assign max_index   = r_max_index;
    assign tie         = r_tie;
    assign timeout     = r_timeout;
    assign no_winner   = r_no_winner;
    assign o_dbg_state = r_state;

`ifdef MAXNET_ITER_COUNT_EN
    // The counter only moves during ITER, so it is stable while done=1.
    assign iter_count = r_iter;
`endif

endmodule
